// File: rtl/blink_rate_controller_if.sv
// Bundles the push-button inputs and LED/status outputs of the blink rate
// controller into one port.
//   KEY     : raw active-low push buttons (0 = pressed), asynchronous
//   LEDR    : 8-bit blink counter
//   RATE    : one-hot rate multiplier (0001=x1, 0010=x2, 0100=x4, 1000=x8)
//   RUNNING : 1 while running, 0 while paused
//   TICK    : single-cycle pulse on each accumulator crossing
// The slave modport is the controller side; master is the board/bench side.
interface blink_rate_controller_if;
  logic [3:0] KEY;
  logic [7:0] LEDR;
  logic [3:0] RATE;
  logic       RUNNING;
  logic       TICK;

  modport master (output KEY, input LEDR, input RATE, input RUNNING, input TICK);
  modport slave  (input KEY, output LEDR, output RATE, output RUNNING, output TICK);
endinterface

// File: rtl/blink_rate_controller.sv
// Blink rate controller for the LEDR bank.
// Debounces the four active-low push buttons, turns debounced presses into
// commands (KEY[0] rate down, KEY[1] rate up, KEY[2] run/pause toggle,
// KEY[3] clear) and runs a rate-weighted tick accumulator that advances the
// 8-bit LED counter.
// Ports:
//   CLOCK_50 : board clock, all logic on the rising edge
//   RESET    : synchronous reset, active-high
//   bus      : KEY in; LEDR, RATE, RUNNING, TICK out (slave modport)
module blink_rate_controller #(
  parameter int TICK_LIMIT      = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACC_W           = 27
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET,
  blink_rate_controller_if.slave bus
);

  // The debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int                 CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ACC_W-1:0]   LIMIT    = ACC_W'(TICK_LIMIT);

  typedef enum logic {RUN, PAUSE} state_t;

  logic [3:0]       sync_a;
  logic [3:0]       sync_b;
  logic [3:0]       level;
  logic [3:0]       level_d;
  logic [3:0]       press;
  logic [CNT_W-1:0] count [4];

  state_t           state;
  logic [3:0]       rate;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [7:0]       led;
  logic             tick;
  logic             tick_hit;

  // Input path. The debounced level follows the synchronised key only after
  // it has disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement
  // restarts the count. A press is a registered 1->0 edge of the level.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync_a  <= '1;
      sync_b  <= '1;
      level   <= '1;
      level_d <= '1;
      press   <= '0;
      for (int i = 0; i < 4; i++) begin
        count[i] <= '0;
      end
    end else begin
      sync_a  <= bus.KEY;
      sync_b  <= sync_a;
      level_d <= level;
      press   <= level_d & ~level;
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == level[i]) begin
          count[i] <= '0;
        end else if (count[i] == CNT_LAST) begin
          level[i] <= sync_b[i];
          count[i] <= '0;
        end else begin
          count[i] <= count[i] + CNT_W'(1);
        end
      end
    end
  end

  // The one-hot rate code is numerically equal to the multiplier itself.
  always_comb begin
    sum      = acc + ACC_W'(rate);
    tick_hit = (sum >= LIMIT);
  end

  // Run/pause FSM with the accumulator. Clear is applied last so that it
  // overrides a tick landing on the same cycle; rate changes take effect
  // from the following cycle because this cycle's sum used the old rate.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= RUN;
      rate  <= 4'b0001;
      acc   <= '0;
      led   <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (state == RUN) begin
        if (tick_hit) begin
          acc  <= sum - LIMIT;
          led  <= led + 8'd1;
          tick <= 1'b1;
        end else begin
          acc <= sum;
        end
      end
      if (press[3]) begin
        acc  <= '0;
        led  <= '0;
        tick <= 1'b0;
      end
      if (press[2]) begin
        state <= (state == RUN) ? PAUSE : RUN;
      end
      if (press[1] && !press[0]) begin
        rate <= rate[3] ? rate : (rate << 1);
      end else if (press[0] && !press[1]) begin
        rate <= rate[0] ? rate : (rate >> 1);
      end
    end
  end

  assign bus.LEDR    = led;
  assign bus.RATE    = rate;
  assign bus.RUNNING = (state == RUN);
  assign bus.TICK    = tick;

endmodule

// File: tb/tb_blink_rate_controller.sv
// Directed self-checking bench for blink_rate_controller with small
// parameters (TICK_LIMIT=10, DEBOUNCE_CYCLES=4), so a key press takes
// effect 7 edges after the first edge that samples it low.
module tb_blink_rate_controller;
  localparam int TICK_LIMIT      = 10;
  localparam int DEBOUNCE_CYCLES = 4;

  logic clock_50 = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit [0:9] x8_pattern;

  blink_rate_controller_if bus ();

  blink_rate_controller #(
    .TICK_LIMIT      (TICK_LIMIT),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACC_W           (27)
  ) dut (
    .CLOCK_50 (clock_50),
    .RESET    (reset),
    .bus      (bus)
  );

  always #5 clock_50 = ~clock_50;

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_50);
      #1;
    end
  endtask

  // Bits set in pressed are driven low on KEY.
  task automatic applyStimulus(input logic [3:0] pressed);
    bus.KEY = ~pressed;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(4'b0000);
    step(2);
    reset = 1'b0;
  endtask

  // Full press: held 8 edges then released for 8 edges.
  task automatic pressKey(input logic [3:0] pressed);
    applyStimulus(pressed);
    step(8);
    applyStimulus(4'b0000);
    step(8);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000);
    x8_pattern = 10'b0111101111;

    // Reset values, then free running at x1: a tick every 10 edges.
    step(2);
    checkOutput("rst_ledr", bus.LEDR, 0);
    checkOutput("rst_rate", bus.RATE, 4'b0001);
    checkOutput("rst_running", bus.RUNNING, 1);
    checkOutput("rst_tick", bus.TICK, 0);
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      checkOutput("t1_tick", bus.TICK, (k % 10 == 0) ? 1 : 0);
      if (k == 10) checkOutput("t1_ledr_first", bus.LEDR, 1);
    end
    checkOutput("t1_ledr_30", bus.LEDR, 3);

    // Rate up three times, then saturation.
    applyStimulus(4'b0010);
    step(7);
    checkOutput("t2_rate_pre1", bus.RATE, 4'b0001);
    step(1);
    checkOutput("t2_rate_up1", bus.RATE, 4'b0010);
    applyStimulus(4'b0000);
    step(8);
    applyStimulus(4'b0010);
    step(7);
    checkOutput("t2_rate_pre2", bus.RATE, 4'b0010);
    step(1);
    checkOutput("t2_rate_up2", bus.RATE, 4'b0100);
    applyStimulus(4'b0000);
    step(8);
    applyStimulus(4'b0010);
    step(7);
    checkOutput("t2_rate_pre3", bus.RATE, 4'b0100);
    step(1);
    checkOutput("t2_rate_up3", bus.RATE, 4'b1000);
    applyStimulus(4'b0000);
    step(8);
    pressKey(4'b0010);
    checkOutput("t2_rate_sat", bus.RATE, 4'b1000);

    // Clear zeroes acc, then x8 gives ticks on 4 of every 5 cycles.
    applyStimulus(4'b1000);
    step(8);
    checkOutput("t2_clear_ledr", bus.LEDR, 0);
    checkOutput("t2_clear_tick", bus.TICK, 0);
    applyStimulus(4'b0000);
    for (int k = 0; k < 10; k++) begin
      step(1);
      checkOutput("t2_x8_tick", bus.TICK, x8_pattern[k]);
    end
    checkOutput("t2_x8_ledr", bus.LEDR, 8);

    // Short glitch on KEY[0] is ignored; a long hold halves once.
    applyStimulus(4'b0001);
    step(3);
    applyStimulus(4'b0000);
    step(20);
    checkOutput("t3_glitch_rate", bus.RATE, 4'b1000);
    applyStimulus(4'b0001);
    step(7);
    checkOutput("t3_hold_pre", bus.RATE, 4'b1000);
    step(1);
    checkOutput("t3_hold_down", bus.RATE, 4'b0100);
    step(42);
    checkOutput("t3_hold_once", bus.RATE, 4'b0100);
    applyStimulus(4'b0000);
    step(10);
    checkOutput("t3_release", bus.RATE, 4'b0100);

    // Pause with acc=7 at x1 (pause lands on edge 17), resume ticks 3 later.
    applyReset();
    step(9);
    applyStimulus(4'b0100);
    step(1);
    checkOutput("t4_tick10", bus.TICK, 1);
    checkOutput("t4_ledr10", bus.LEDR, 1);
    step(6);
    checkOutput("t4_still_run", bus.RUNNING, 1);
    step(1);
    checkOutput("t4_paused", bus.RUNNING, 0);
    applyStimulus(4'b0000);
    for (int k = 0; k < 100; k++) begin
      step(1);
      checkOutput("t4_pause_tick", bus.TICK, 0);
    end
    checkOutput("t4_pause_ledr", bus.LEDR, 1);
    checkOutput("t4_pause_state", bus.RUNNING, 0);
    applyStimulus(4'b0100);
    step(7);
    checkOutput("t4_resume_pre", bus.RUNNING, 0);
    step(1);
    checkOutput("t4_resumed", bus.RUNNING, 1);
    applyStimulus(4'b0000);
    step(2);
    checkOutput("t4_resume_tick2", bus.TICK, 0);
    step(1);
    checkOutput("t4_resume_tick3", bus.TICK, 1);
    checkOutput("t4_resume_ledr", bus.LEDR, 2);

    // LEDR wraps 255 -> 0 at x1 (tick on every 10th edge).
    applyReset();
    step(2549);
    checkOutput("t5_ledr_254", bus.LEDR, 254);
    step(1);
    checkOutput("t5_ledr_255", bus.LEDR, 255);
    step(9);
    checkOutput("t5_hold_255", bus.LEDR, 255);
    step(1);
    checkOutput("t5_wrap_ledr", bus.LEDR, 0);
    checkOutput("t5_wrap_tick", bus.TICK, 1);

    // Clear plus rate-up on the edge that would tick (edge 2570).
    step(2);
    applyStimulus(4'b1010);
    step(7);
    checkOutput("t5_combo_pre", bus.RATE, 4'b0001);
    step(1);
    checkOutput("t5_combo_ledr", bus.LEDR, 0);
    checkOutput("t5_combo_tick", bus.TICK, 0);
    checkOutput("t5_combo_rate", bus.RATE, 4'b0010);
    checkOutput("t5_combo_run", bus.RUNNING, 1);
    applyStimulus(4'b0000);
    step(4);
    checkOutput("t5_x2_notick", bus.TICK, 0);
    step(1);
    checkOutput("t5_x2_tick", bus.TICK, 1);
    checkOutput("t5_x2_ledr", bus.LEDR, 1);

    // Up and down together leave the rate alone.
    step(8);
    pressKey(4'b0011);
    checkOutput("t5_updown", bus.RATE, 4'b0010);

    // Reset for one cycle while paused at x8.
    pressKey(4'b0010);
    pressKey(4'b0010);
    pressKey(4'b0100);
    checkOutput("t6_pre_rate", bus.RATE, 4'b1000);
    checkOutput("t6_pre_run", bus.RUNNING, 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("t6_ledr", bus.LEDR, 0);
    checkOutput("t6_rate", bus.RATE, 4'b0001);
    checkOutput("t6_running", bus.RUNNING, 1);
    checkOutput("t6_tick", bus.TICK, 0);

    // A key held through reset is a new press after the full latency.
    applyStimulus(4'b0010);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(7);
    checkOutput("t6_held_pre", bus.RATE, 4'b0001);
    step(1);
    checkOutput("t6_held_press", bus.RATE, 4'b0010);
    applyStimulus(4'b0000);
    step(10);
    checkOutput("t6_held_once", bus.RATE, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
